// File: rtl/lab3_pkg.sv
// Shared types, constants and the golden gate function for the lab3 exerciser.
package lab3_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam int unsigned NUM_VECTORS = 8;

    // Reference behaviour of the lab3 gate: y = a&b | c.
    function automatic logic lab3_expected(input logic a, input logic b, input logic c);
        return (a & b) | c;
    endfunction

endpackage

// File: rtl/lab3_exerciser_settle_timer.sv
// Settle-time counter: clears on request, counts while enabled and flags the
// last settle cycle so the sequencer can move to sampling.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [7:0] count;

    // Settle counter: clear has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign tc = (count == 8'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/lab3_exerciser.sv
// Self-test driver/checker for the lab3 gate: sweeps all 8 input vectors,
// lets each settle, samples y and records a per-vector fail map.
module lab3_exerciser
    import lab3_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    input  logic       y_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    state_t     state;
    logic [2:0] idx;
    logic       tmr_clear;
    logic       tmr_en;
    logic       tmr_tc;
    logic       exp_y;
    logic       mismatch;
    logic [3:0] err_next;

    // Counter restarts on a new sweep and whenever the next vector is applied.
    assign tmr_clear = ((state == IDLE) && start) ||
                       ((state == CHECK) && (idx != 3'(NUM_VECTORS - 1)));
    assign tmr_en    = (state == SETTLE);

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (tmr_clear),
        .en    (tmr_en),
        .tc    (tmr_tc)
    );

    // Only meaningful in CHECK; never drives an output combinationally.
    assign exp_y    = lab3_expected(a_o, b_o, c_o);
    assign mismatch = (y_i != exp_y);
    // At most one increment per vector, so 8 is the ceiling without clamping.
    assign err_next = err_count + {3'b000, mismatch};

    // Sweep sequencer with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_o       <= 1'b0;
            b_o       <= 1'b0;
            c_o       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx             <= '0;
                        {a_o, b_o, c_o} <= 3'b000;
                        err_count       <= '0;
                        fail_vec        <= '0;
                        pass            <= 1'b0;
                        busy            <= 1'b1;
                        state           <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (tmr_tc) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_vec[idx] <= 1'b1;
                    end
                    err_count <= err_next;
                    if (idx == 3'(NUM_VECTORS - 1)) begin
                        // pass is settled together with done so it is valid during the pulse.
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 4'd0);
                        state <= DONE;
                    end else begin
                        idx             <= idx + 3'd1;
                        {a_o, b_o, c_o} <= idx + 3'd1;
                        state           <= SETTLE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab3_exerciser.sv
// Directed bench for lab3_exerciser: models good and faulty gates and checks
// drives, timing and the reported results against hand-computed values.
module tb_lab3_exerciser;
    import lab3_pkg::*;

    localparam int S  = 4;
    localparam int S1 = S + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       a_o, b_o, c_o;
    logic       y_i;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [7:0] fail_vec;

    int n_total = 0;
    int n_bad   = 0;

    lab3_exerciser #(
        .SETTLE_CYCLES(S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_o       (a_o),
        .b_o       (b_o),
        .c_o       (c_o),
        .y_i       (y_i),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_drv"},  32'({a_o, b_o, c_o}), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_err"},  32'(err_count), 32'd0);
        check({tag, "_fail"}, 32'(fail_vec), 32'd0);
    endtask

    // mode: 0 good gate, 1 y=a&b, 2 y stuck 0, 3 wrong except in the CHECK cycle.
    // poke_*: cycle index at which an extra start pulse is driven (-1 = none).
    // abort_at: cycle index at which rst is asserted mid-cycle (-1 = none).
    task automatic sweep(input int mode, input int poke_a, input int poke_b,
                         input int abort_at, input logic [7:0] want_fail, input int want_err);
        int   ndone = 0;
        logic exp_y;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int m = 0; m <= 41; m++) begin
            if (m == abort_at) begin
                #2;
                rst = 1'b1;
                #1;
                check_all_zero("abort");
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                repeat (50) begin
                    @(posedge clk);
                    #1;
                    if (done) ndone++;
                end
                check("abort_no_done", 32'(ndone), 32'd0);
                check("abort_idle_busy", 32'(busy), 32'd0);
                return;
            end
            if (done) ndone++;
            if (m < 8 * S1) begin
                check("drive", 32'({a_o, b_o, c_o}), 32'(m / S1));
                check("busy", 32'(busy), 32'd1);
            end else if (m == 8 * S1) begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_done", 32'(busy), 32'd0);
                check("pass_at_done", 32'(pass), 32'(want_err == 0));
            end else begin
                check("done_low", 32'(done), 32'd0);
                check("pass", 32'(pass), 32'(want_err == 0));
                check("err_count", 32'(err_count), 32'(want_err));
                check("fail_vec", 32'(fail_vec), 32'(want_fail));
            end
            exp_y = lab3_expected(a_o, b_o, c_o);
            case (mode)
                1:       y_i = a_o & b_o;
                2:       y_i = 1'b0;
                3:       y_i = ((m % S1) == S) ? exp_y : ~exp_y;
                default: y_i = exp_y;
            endcase
            start = (m == poke_a) || (m == poke_b);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("done_count", 32'(ndone), 32'd1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        y_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        sweep(0, -1, -1, -1, 8'h00, 0);
        sweep(1, -1, -1, -1, 8'h2A, 3);
        sweep(2, -1, -1, -1, 8'hEA, 5);
        sweep(3, -1, -1, -1, 8'h00, 0);
        sweep(0,  5, 20, -1, 8'h00, 0);
        sweep(2, -1, -1, 3 * S1 + 2, 8'h00, 0);
        sweep(0, -1, -1, -1, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
